// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access pipeline stage: operation codes,
// register-bus widths, reset/NOP constants and the load/store decoder.
package mem_access_pkg;

  localparam logic RstEnable  = 1'b1;
  localparam int   RegBus     = 32;
  localparam int   RegAddrBus = 5;

  localparam logic [RegBus-1:0]     ZeroWord   = 32'h0000_0000;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = 5'b00000;

  typedef logic [RegBus-1:0]     reg_t;
  typedef logic [RegAddrBus-1:0] reg_addr_t;

  // ALU operation codes seen by the memory stage
  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Decoded view of one memory access
  typedef struct packed {
    logic      is_mem;
    logic      is_store;
    logic      is_signed;
    acc_size_e size;
  } acc_t;

  function automatic acc_t decode_access(input logic [7:0] aluop);
    acc_t a;
    a = '0;
    case (aluop)
      EXE_LB_OP:  a = '{is_mem: 1'b1, is_store: 1'b0, is_signed: 1'b1, size: SZ_BYTE};
      EXE_LBU_OP: a = '{is_mem: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: SZ_BYTE};
      EXE_LH_OP:  a = '{is_mem: 1'b1, is_store: 1'b0, is_signed: 1'b1, size: SZ_HALF};
      EXE_LHU_OP: a = '{is_mem: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: SZ_HALF};
      EXE_LW_OP:  a = '{is_mem: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: SZ_WORD};
      EXE_SB_OP:  a = '{is_mem: 1'b1, is_store: 1'b1, is_signed: 1'b0, size: SZ_BYTE};
      EXE_SH_OP:  a = '{is_mem: 1'b1, is_store: 1'b1, is_signed: 1'b0, size: SZ_HALF};
      EXE_SW_OP:  a = '{is_mem: 1'b1, is_store: 1'b1, is_signed: 1'b0, size: SZ_WORD};
      default:    a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
interface mem_access_if;
  import mem_access_pkg::*;

  logic       bus_req;
  logic       bus_we;
  reg_t       bus_addr;
  logic [3:0] bus_sel;
  reg_t       bus_wdata;
  reg_t       bus_rdata;
  logic       bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    output bus_rdata, bus_ack
  );

endinterface

// File: rtl/mem_byte_lane.sv
// Byte-lane steering: byte enables and replicated store data for the bus,
// plus lane extraction and sign/zero extension of the read word.
module mem_byte_lane
  import mem_access_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  acc_t       acc,
  input  logic [1:0] offset,
  input  reg_t       st_src,
  input  reg_t       ld_word,
  output logic [3:0] sel,
  output reg_t       st_data,
  output reg_t       ld_data
);

  // Physical lane index: byte lane 0 is bits 7:0, halfword lane 0 is bits 15:0.
  logic [1:0]  byte_lane;
  logic        half_lane;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Map the byte offset onto a physical lane according to endianness
  always_comb begin
    byte_lane = BIG_ENDIAN ? ~offset    : offset;
    half_lane = BIG_ENDIAN ? ~offset[1] : offset[1];
    byte_val  = ld_word[8*byte_lane +: 8];
    half_val  = ld_word[16*half_lane +: 16];
  end

  // Enables, store replication and load extension per access size
  always_comb begin
    sel     = 4'b0000;
    st_data = ZeroWord;
    ld_data = ZeroWord;
    if (acc.is_mem) begin
      case (acc.size)
        SZ_BYTE: begin
          sel     = 4'b0001 << byte_lane;
          st_data = {4{st_src[7:0]}};
          ld_data = acc.is_signed ? {{24{byte_val[7]}}, byte_val} : {24'b0, byte_val};
        end
        SZ_HALF: begin
          sel     = half_lane ? 4'b1100 : 4'b0011;
          st_data = {2{st_src[15:0]}};
          ld_data = acc.is_signed ? {{16{half_val[15]}}, half_val} : {16'b0, half_val};
        end
        default: begin
          sel     = 4'b1111;
          st_data = st_src;
          ld_data = ld_word;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage. Non-memory operations pass straight through
// to the MEM/WB register; loads and stores run a request/ack handshake on the
// data bus and stall the pipeline until the bus acknowledges.
module mem_access
  import mem_access_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,

  input  reg_addr_t       mem_wd,
  input  logic            mem_wreg,
  input  reg_t            mem_wdata,
  input  reg_t            mem_hi,
  input  reg_t            mem_lo,
  input  logic            mem_whilo,
  input  logic [7:0]      mem_aluop,
  input  reg_t            mem_addr,
  input  reg_t            mem_reg2,

  mem_access_if.master    mem_bus,

  output reg_addr_t       wb_wd,
  output logic            wb_wreg,
  output reg_t            wb_wdata,
  output reg_t            wb_hi,
  output reg_t            wb_lo,
  output logic            wb_whilo,
  output logic            stallreq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  reg_t       rdata_q;
  acc_t       acc;
  logic       in_reset;
  logic       req_raw;
  logic       stall_raw;
  logic [3:0] lane_sel;
  reg_t       lane_st_data;
  reg_t       lane_ld_data;

  assign acc      = decode_access(mem_aluop);
  assign in_reset = (rst == RstEnable);

  mem_byte_lane #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane (
    .acc     (acc),
    .offset  (mem_addr[1:0]),
    .st_src  (mem_reg2),
    .ld_word (rdata_q),
    .sel     (lane_sel),
    .st_data (lane_st_data),
    .ld_data (lane_ld_data)
  );

  // State register; reset abandons any access in flight
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (in_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Read latch: capture bus data on the acknowledging edge of a request
  always_ff @(posedge clk) begin
    // NOTE: this holding register is reset so DONE never exposes X after power-up.
    if (in_reset)                      rdata_q <= ZeroWord;
    else if (req_raw && mem_bus.bus_ack) rdata_q <= mem_bus.bus_rdata;
  end

  // Next-state and handshake control
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d   = state_q;
    req_raw   = 1'b0;
    stall_raw = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc.is_mem) begin
          req_raw   = 1'b1;
          stall_raw = 1'b1;
          state_d   = mem_bus.bus_ack ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        req_raw   = 1'b1;
        stall_raw = 1'b1;
        if (mem_bus.bus_ack) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus drive; everything is zero whenever no request is outstanding
  always_comb begin
    mem_bus.bus_req   = 1'b0;
    mem_bus.bus_we    = 1'b0;
    mem_bus.bus_addr  = ZeroWord;
    mem_bus.bus_sel   = 4'b0000;
    mem_bus.bus_wdata = ZeroWord;
    if (req_raw && !in_reset) begin
      mem_bus.bus_req   = 1'b1;
      mem_bus.bus_we    = acc.is_store;
      mem_bus.bus_addr  = {mem_addr[31:2], 2'b00};
      mem_bus.bus_sel   = lane_sel;
      mem_bus.bus_wdata = acc.is_store ? lane_st_data : ZeroWord;
    end
  end

  assign stallreq = stall_raw && !in_reset;

  // Write-back results: pass-through, with the load result substituted in DONE.
  // Write enables are suppressed while stalling so a frozen access cannot
  // write back early.
  always_comb begin
    wb_wd    = mem_wd;
    wb_wreg  = mem_wreg;
    wb_wdata = mem_wdata;
    wb_hi    = mem_hi;
    wb_lo    = mem_lo;
    wb_whilo = mem_whilo;
    if (in_reset) begin
      wb_wd    = NOPRegAddr;
      wb_wreg  = 1'b0;
      wb_wdata = ZeroWord;
      wb_hi    = ZeroWord;
      wb_lo    = ZeroWord;
      wb_whilo = 1'b0;
    end else if (state_q == ST_DONE) begin
      if (acc.is_mem && !acc.is_store) wb_wdata = lane_ld_data;
    end else if (stall_raw) begin
      wb_wreg  = 1'b0;
      wb_whilo = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: the bench plays both the pipeline and
// the memory, predicts every cycle of each operation from the access rules,
// and a compare process checks the DUT against that prediction.
module tb_mem_access;
  import mem_access_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] mem_wd;
  logic       mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_addr, mem_reg2;
  logic       mem_whilo;
  logic [7:0] mem_aluop;
  logic [4:0] wb_wd;
  logic       wb_wreg, wb_whilo, stallreq;
  logic [31:0] wb_wdata, wb_hi, wb_lo;

  mem_access_if bus_if ();

  mem_access #(.BIG_ENDIAN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .mem_whilo (mem_whilo),
    .mem_aluop (mem_aluop),
    .mem_addr  (mem_addr),
    .mem_reg2  (mem_reg2),
    .mem_bus   (bus_if),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata),
    .wb_hi     (wb_hi),
    .wb_lo     (wb_lo),
    .wb_whilo  (wb_whilo),
    .stallreq  (stallreq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  aluop;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata, hi, lo;
    logic        whilo;
    logic [31:0] addr, reg2, rdata;
    int          waits;
    int          ack_noise;   // -1: random ack on idle cycles, else forced value
  } op_t;

  typedef struct packed {
    logic        req, stall, we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        chk_wdata, chk_wb;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wb_wdata, hi, lo;
    logic        whilo;
  } exp_t;

  exp_t exp_c;
  bit   exp_valid = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Observations of the most recent operation, pinned against literals
  int          obs_stall;
  logic        obs_req_first, obs_we;
  logic [31:0] obs_addr, obs_wdata, obs_wb_wdata;
  logic [3:0]  obs_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_mem(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  function automatic bit is_store(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  // Big-endian: byte offset 0 is the most significant byte
  function automatic logic [3:0] model_sel(input logic [7:0] op, input logic [31:0] addr);
    int off = int'(addr[1:0]);
    if (op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP}) return 4'b1000 >> off;
    if (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) return addr[1] ? 4'b0011 : 4'b1100;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_store(input logic [7:0] op, input logic [31:0] r);
    if (op == EXE_SB_OP) return {4{r[7:0]}};
    if (op == EXE_SH_OP) return {2{r[15:0]}};
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int off = int'(addr[1:0]);
    logic [31:0] b, h;
    b = (rd >> (24 - 8 * off)) & 32'hFF;
    h = addr[1] ? (rd & 32'hFFFF) : (rd >> 16);
    case (op)
      EXE_LB_OP:  return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      EXE_LBU_OP: return b;
      EXE_LH_OP:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      EXE_LHU_OP: return h;
      default:    return rd;
    endcase
  endfunction

  function automatic op_t mk_op(input logic [7:0] aluop, input logic [4:0] wd, input logic wreg,
                                input logic [31:0] wdata, input logic [31:0] addr,
                                input logic [31:0] reg2, input logic [31:0] rdata, input int waits);
    op_t o;
    o.aluop = aluop; o.wd = wd; o.wreg = wreg; o.wdata = wdata;
    o.hi = $urandom; o.lo = $urandom; o.whilo = 1'($urandom_range(0, 1));
    o.addr = addr; o.reg2 = reg2; o.rdata = rdata; o.waits = waits; o.ack_noise = -1;
    return o;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (exp_valid) begin
      check("stallreq", stallreq, exp_c.stall);
      check("bus_req", bus_if.bus_req, exp_c.req);
      check("bus_we", bus_if.bus_we, exp_c.we);
      check("bus_addr", bus_if.bus_addr, exp_c.addr);
      check("bus_sel", bus_if.bus_sel, exp_c.sel);
      if (exp_c.chk_wdata) check("bus_wdata", bus_if.bus_wdata, exp_c.wdata);
      if (exp_c.chk_wb) begin
        check("wb_wd", wb_wd, exp_c.wd);
        check("wb_wreg", wb_wreg, exp_c.wreg);
        check("wb_wdata", wb_wdata, exp_c.wb_wdata);
        check("wb_hi", wb_hi, exp_c.hi);
        check("wb_lo", wb_lo, exp_c.lo);
        check("wb_whilo", wb_whilo, exp_c.whilo);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_op_inputs(input op_t op);
    mem_wd = op.wd; mem_wreg = op.wreg; mem_wdata = op.wdata;
    mem_hi = op.hi; mem_lo = op.lo; mem_whilo = op.whilo;
    mem_aluop = op.aluop; mem_addr = op.addr; mem_reg2 = op.reg2;
  endtask

  // Run one operation for its predicted length (or only `cut` cycles)
  task automatic run_op(input op_t op, input int cut);
    bit mem = is_mem(op.aluop);
    bit st  = is_store(op.aluop);
    int n   = mem ? op.waits + 2 : 1;
    bit noise;
    if (cut >= 0 && cut < n) n = cut;
    obs_stall = 0;
    for (int c = 0; c < n; c++) begin
      rst = 1'b0;
      drive_op_inputs(op);
      noise = (op.ack_noise < 0) ? 1'($urandom_range(0, 1)) : 1'(op.ack_noise);
      if (mem && c == op.waits) begin
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = op.rdata;
      end else begin
        bus_if.bus_ack = (mem && c < op.waits) ? 1'b0 : noise;
        bus_if.bus_rdata = $urandom;
      end
      exp_c = '0;
      if (mem && c <= op.waits) begin
        exp_c.req = 1'b1; exp_c.stall = 1'b1; exp_c.we = st;
        exp_c.addr = op.addr & 32'hFFFF_FFFC;
        exp_c.sel = model_sel(op.aluop, op.addr);
        exp_c.wdata = model_store(op.aluop, op.reg2);
        exp_c.chk_wdata = st;
      end else begin
        exp_c.chk_wdata = 1'b1;
        exp_c.chk_wb = 1'b1;
        exp_c.wd = op.wd; exp_c.wreg = op.wreg; exp_c.hi = op.hi; exp_c.lo = op.lo;
        exp_c.whilo = op.whilo;
        exp_c.wb_wdata = (mem && !st) ? model_load(op.aluop, op.addr, op.rdata) : op.wdata;
      end
      exp_valid = 1'b1;
      @(negedge clk);
      if (stallreq) obs_stall++;
      if (c == 0) begin
        obs_req_first = bus_if.bus_req; obs_we = bus_if.bus_we; obs_addr = bus_if.bus_addr;
        obs_sel = bus_if.bus_sel; obs_wdata = bus_if.bus_wdata;
      end
      obs_wb_wdata = wb_wdata;
      @(posedge clk);
      #1;
    end
  endtask

  // One reset cycle with a live memory op and random bus activity on the inputs
  task automatic reset_cycle();
    rst = 1'b1;
    drive_op_inputs(mk_op(EXE_LW_OP, 5'($urandom), 1'b1, $urandom, $urandom, $urandom, 0, 0));
    bus_if.bus_ack = 1'($urandom_range(0, 1));
    bus_if.bus_rdata = $urandom;
    exp_c = '0;
    exp_c.chk_wdata = 1'b1;
    exp_c.chk_wb = 1'b1;
    exp_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    op_t o;
    logic [7:0] mem_codes [8] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
                                  EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    rst = 1'b1;
    drive_op_inputs(mk_op(EXE_NOP_OP, 0, 0, 0, 0, 0, 0, 0));
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = '0;

    reset_cycle();
    reset_cycle();

    // ALU result pass-through
    run_op(mk_op(EXE_ADD_OP, 5'd5, 1'b1, 32'h1234, $urandom, $urandom, 0, 0), -1);
    check("add wb_wdata", obs_wb_wdata, 32'h0000_1234);
    check("add stall cycles", obs_stall, 0);
    check("add bus_req", obs_req_first, 1'b0);

    // LW with three wait cycles
    run_op(mk_op(EXE_LW_OP, 5'd7, 1'b1, $urandom, 32'h100, $urandom, 32'hDEAD_BEEF, 3), -1);
    check("lw stall cycles", obs_stall, 4);
    check("lw result", obs_wb_wdata, 32'hDEAD_BEEF);
    check("lw bus_addr", obs_addr, 32'h0000_0100);
    check("lw bus_sel", obs_sel, 4'b1111);

    // LB / LBU on the least significant lane
    run_op(mk_op(EXE_LB_OP, 5'd8, 1'b1, $urandom, 32'h103, $urandom, 32'h0000_00F0, 0), -1);
    check("lb result", obs_wb_wdata, 32'hFFFF_FFF0);
    check("lb bus_sel", obs_sel, 4'b0001);
    run_op(mk_op(EXE_LBU_OP, 5'd9, 1'b1, $urandom, 32'h103, $urandom, 32'h0000_00F0, 0), -1);
    check("lbu result", obs_wb_wdata, 32'h0000_00F0);
    check("lbu bus_sel", obs_sel, 4'b0001);

    // SH at the upper halfword offset, zero-wait ack
    run_op(mk_op(EXE_SH_OP, 5'd0, 1'b0, 32'h0, 32'h202, 32'h0000_ABCD, 0, 0), -1);
    check("sh bus_we", obs_we, 1'b1);
    check("sh bus_addr", obs_addr, 32'h0000_0200);
    check("sh bus_sel", obs_sel, 4'b0011);
    check("sh bus_wdata", obs_wdata, 32'hABCD_ABCD);
    check("sh stall cycles", obs_stall, 1);

    // SW immediately followed by LW
    run_op(mk_op(EXE_SW_OP, 5'd0, 1'b0, 32'h0, 32'h300, 32'h1357_9BDF, 0, 1), -1);
    run_op(mk_op(EXE_LW_OP, 5'd10, 1'b1, $urandom, 32'h304, $urandom, 32'h0BAD_F00D, 0), -1);
    check("b2b second bus_req", obs_req_first, 1'b1);
    check("b2b lw result", obs_wb_wdata, 32'h0BAD_F00D);

    // Reset in BUSY, then a late ack on a flushed pipeline
    run_op(mk_op(EXE_LW_OP, 5'd11, 1'b1, $urandom, 32'h400, $urandom, 32'h1111_2222, 5), 2);
    reset_cycle();
    o = mk_op(EXE_NOP_OP, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);
    o.ack_noise = 1;
    run_op(o, -1);
    check("late ack bus_req", obs_req_first, 1'b0);
    check("late ack stall", obs_stall, 0);
    run_op(mk_op(EXE_LW_OP, 5'd12, 1'b1, $urandom, 32'h404, $urandom, 32'h55AA_1234, 0), -1);
    check("post-reset lw stall", obs_stall, 1);
    check("post-reset lw result", obs_wb_wdata, 32'h55AA_1234);

    // Randomized traffic with occasional mid-access resets
    for (int i = 0; i < 400; i++) begin
      int cut;
      if ($urandom_range(0, 9) < 3)
        o = mk_op(8'($urandom_range(0, 127)), 5'($urandom), 1'($urandom_range(0, 1)), $urandom,
                  $urandom, $urandom, $urandom, 0);
      else
        o = mk_op(mem_codes[$urandom_range(0, 7)], 5'($urandom), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 4));
      if (is_mem(o.aluop) && $urandom_range(0, 19) == 0) begin
        cut = $urandom_range(1, o.waits + 1);
        run_op(o, cut);
        reset_cycle();
      end else begin
        run_op(o, -1);
      end
    end

    exp_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
